// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_prog FIFO: width derivation helpers,
// the parameter legality check and the FWFT output-stage state encoding.
package fifo_pkg;

  // Output register state used only when FIFO_FWFT_EN is defined.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  localparam int MIN_DEPTH = 4;

  // Pointer width: wraps DEPTH-1 -> 0 naturally for a power-of-two depth.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: must hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int pf_thresh, input int pe_thresh);
    return (width >= 1) && (depth >= MIN_DEPTH) &&
           ((depth & (depth - 1)) == 0) &&
           (pf_thresh >= 1) && (pf_thresh <= depth - 1) &&
           (pe_thresh >= 0) && (pe_thresh <= depth - 2) &&
           (pe_thresh < pf_thresh);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The storage array is never reset; only the read data register is.
module sdp_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered, holds its value when not reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable full/empty thresholds, occupancy count
// and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-
// through output; otherwise reads are registered with a one-cycle valid strobe.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int DEPTH             = 16,
  parameter int PROG_FULL_THRESH  = DEPTH - 4,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     prog_full,
  output logic                     prog_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PF_LVL   = CNT_W'(PROG_FULL_THRESH);
  localparam logic [CNT_W-1:0] PE_LVL   = CNT_W'(PROG_EMPTY_THRESH);

  if (!params_ok(WIDTH, DEPTH, PROG_FULL_THRESH, PROG_EMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo_prog: illegal WIDTH/DEPTH/threshold combination");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              wr_acc, rd_acc, ram_re, empty_nxt;

  // Accept/reject decisions and next occupancy.
  always_comb begin
    rd_acc    = rd_en && !empty;
    wr_acc    = wr_en && (!full || rd_acc);
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

`ifdef FIFO_FWFT_EN
  // The RAM read register doubles as the output stage; count includes it,
  // so the RAM itself holds count minus the word currently presented.
  out_state_e       state, state_nxt;
  logic [CNT_W-1:0] ram_cnt;

  // Output stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OUT_EMPTY;
    else     state <= state_nxt;
  end

  // Prefetch the head word whenever the output stage is free or being consumed.
  always_comb begin
    state_nxt = state;
    ram_re    = 1'b0;
    ram_cnt   = count - ((state == OUT_VALID) ? CNT_W'(1) : '0);
    case (state)
      OUT_EMPTY: begin
        if (ram_cnt != '0) begin
          ram_re    = 1'b1;
          state_nxt = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (rd_acc) begin
          if (ram_cnt != '0) ram_re    = 1'b1;
          else               state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  assign empty_nxt = (state_nxt != OUT_VALID);
  assign valid     = (state == OUT_VALID);
`else
  assign ram_re    = rd_acc;
  assign empty_nxt = (count_nxt == '0);

  // One-cycle strobe marking fresh read data on dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= 1'b0;
    else     valid <= rd_acc;
  end
`endif

  // Pointers advance on accepted writes and on RAM reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ram_re) rd_ptr <= rd_ptr + ADDR_W'(1);
    end
  end

  // Count, flags and error pulses, all registered from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count      <= count_nxt;
      full       <= (count_nxt == FULL_LVL);
      empty      <= empty_nxt;
      prog_full  <= (count_nxt >= PF_LVL);
      prog_empty <= (count_nxt <= PE_LVL);
      overflow   <= wr_en && !wr_acc;
      underflow  <= rd_en && !rd_acc;
    end
  end

  assign data_count = count;

  sdp_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog (WIDTH=32, DEPTH=16, thresholds 12/2).
// Covers standard mode by default and the FWFT path when FIFO_FWFT_EN is set.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        valid, full, empty, prog_full, prog_empty, overflow, underflow;
  logic [4:0]  data_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          m_count = 0;
  logic [5:0]  exp_flags;
  logic [31:0] last_dout = '0;

  sync_fifo_prog #(
    .WIDTH             (32),
    .DEPTH             (16),
    .PROG_FULL_THRESH  (12),
    .PROG_EMPTY_THRESH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .valid      (valid),
    .full       (full),
    .empty      (empty),
    .prog_full  (prog_full),
    .prog_empty (prog_empty),
    .data_count (data_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({full, prog_full, prog_empty, empty, overflow, underflow, valid} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0011000",
               {full, prog_full, prog_empty, empty, overflow, underflow, valid});
    end
    checks++;
    if (data_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", data_count); end
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

  task automatic test_reset_mid_burst;
    wr_en = 1'b1;
    repeat (9) begin
      din = $urandom;
      @(posedge clk);
    end
    #1;
    checks++;
    if (data_count !== 5'd9) begin errors++; $display("FAIL midrst_precount: got %0d expected 9", data_count); end
    #2;
    rst = 1'b1;
    wr_en = 1'b0;
    #1;
    checks++;
    if ({full, prog_full, prog_empty, empty, overflow, underflow, valid} !== 7'b0011000) begin
      errors++;
      $display("FAIL midrst_flags: got %b expected 0011000",
               {full, prog_full, prog_empty, empty, overflow, underflow, valid});
    end
    checks++;
    if (data_count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", data_count); end
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL midrst_dout: got %h expected 0", dout); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft;
    logic [31:0] w;
    w = $urandom;
    sb.push_back(w);
    wr_en = 1'b1; din = w;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++;
    if ({valid, empty, data_count} !== {1'b0, 1'b1, 5'd1}) begin
      errors++; $display("FAIL fwft_edge1: got v=%b e=%b c=%0d expected v=0 e=1 c=1", valid, empty, data_count);
    end
    @(posedge clk); #1;
    checks++;
    if ({valid, empty, data_count} !== {1'b1, 1'b0, 5'd1}) begin
      errors++; $display("FAIL fwft_edge2: got v=%b e=%b c=%0d expected v=1 e=0 c=1", valid, empty, data_count);
    end
    checks++;
    if (dout !== sb[0]) begin errors++; $display("FAIL fwft_head: got %h expected %h", dout, sb[0]); end
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({valid, empty, data_count, underflow} !== {1'b1 ^ 1'b1, 1'b1, 5'd0, 1'b0}) begin
      errors++; $display("FAIL fwft_consume: got v=%b e=%b c=%0d u=%b expected v=0 e=1 c=0 u=0",
                         valid, empty, data_count, underflow);
    end
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = $urandom;
      sb.push_back(din);
      @(posedge clk);
    end
    #1;
    wr_en = 1'b0;
    checks++;
    if ({full, prog_full, valid, data_count} !== {1'b1, 1'b1, 1'b1, 5'd16}) begin
      errors++; $display("FAIL fwft_full: got f=%b pf=%b v=%b c=%0d expected f=1 pf=1 v=1 c=16",
                         full, prog_full, valid, data_count);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (valid !== 1'b1 || dout !== sb[0]) begin
        errors++; $display("FAIL fwft_drain: got v=%b %h expected v=1 %h", valid, dout, sb[0]);
      end
      void'(sb.pop_front());
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
    end
    checks++;
    if ({empty, valid, data_count} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL fwft_drained: got e=%b v=%b c=%0d expected e=1 v=0 c=0", empty, valid, data_count);
    end
  endtask
`else
  // One clock of stimulus; the reference model decides acceptance, pushes
  // accepted writes and pops the scoreboard whenever the DUT presents data.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    logic racc, wacc;
    logic [31:0] exp;
    wr_en = w; rd_en = r; din = d;
    racc = r && (m_count > 0);
    wacc = w && ((m_count < 16) || racc);
    if (wacc) sb.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
    exp_flags = {m_count == 16, m_count >= 12, m_count <= 2, m_count == 0, w && !wacc, r && !racc};
    checks++;
    if (valid !== racc) begin errors++; $display("FAIL sb_valid: got %b expected %b", valid, racc); end
    if (valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL sb_data: got %h expected no data", dout);
      end else begin
        exp = sb.pop_front();
        if (dout !== exp) begin errors++; $display("FAIL sb_data: got %h expected %h", dout, exp); end
      end
      last_dout = dout;
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, $urandom);
      checks++;
      if (data_count !== 5'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", data_count, i); end
      checks++;
      if ({full, prog_full, prog_empty, empty, overflow, underflow} !== {i == 16, i >= 12, i <= 2, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL fill_flags@%0d: got %b expected %b", i,
                           {full, prog_full, prog_empty, empty, overflow, underflow},
                           {i == 16, i >= 12, i <= 2, 1'b0, 1'b0, 1'b0});
      end
    end
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    checks++;
    if ({overflow, full, data_count} !== {1'b1, 1'b1, 5'd16}) begin
      errors++; $display("FAIL overflow_pulse: got o=%b f=%b c=%0d expected o=1 f=1 c=16", overflow, full, data_count);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_drain;
    for (int i = 15; i >= 0; i--) begin
      step(1'b0, 1'b1, 32'h0);
      checks++;
      if (data_count !== 5'(i)) begin errors++; $display("FAIL drain_count: got %0d expected %0d", data_count, i); end
      checks++;
      if ({full, prog_full, prog_empty, empty, overflow, underflow} !== {1'b0, i >= 12, i <= 2, i == 0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL drain_flags@%0d: got %b expected %b", i,
                           {full, prog_full, prog_empty, empty, overflow, underflow},
                           {1'b0, i >= 12, i <= 2, i == 0, 1'b0, 1'b0});
      end
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if ({underflow, empty, dout} !== {1'b1, 1'b1, last_dout}) begin
      errors++; $display("FAIL underflow_pulse: got u=%b e=%b %h expected u=1 e=1 %h", underflow, empty, dout, last_dout);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, $urandom);
      checks++;
      if ({full, overflow, data_count} !== {1'b1, 1'b0, 5'd16}) begin
        errors++; $display("FAIL full_rw: got f=%b o=%b c=%0d expected f=1 o=0 c=16", full, overflow, data_count);
      end
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h0);
    checks++;
    if ({empty, data_count, sb.size() == 0} !== {1'b1, 5'd0, 1'b1}) begin
      errors++; $display("FAIL full_rw_drained: got e=%b c=%0d left=%0d expected e=1 c=0 left=0", empty, data_count, sb.size());
    end
  endtask

  task automatic test_empty_rw;
    step(1'b1, 1'b1, 32'hA5A5_0001);
    checks++;
    if ({underflow, overflow, empty, data_count} !== {1'b1, 1'b0, 1'b0, 5'd1}) begin
      errors++; $display("FAIL empty_rw: got u=%b o=%b e=%b c=%0d expected u=1 o=0 e=0 c=1",
                         underflow, overflow, empty, data_count);
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if ({valid, dout, empty} !== {1'b1, 32'hA5A5_0001, 1'b1}) begin
      errors++; $display("FAIL empty_rw_read: got v=%b %h e=%b expected v=1 a5a50001 e=1", valid, dout, empty);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, $urandom);
      checks++;
      if ({data_count, flags_ok()} !== {5'd1, 1'b1}) begin
        errors++; $display("FAIL b2b: got c=%0d flags=%b expected c=1 flags=%b", data_count,
                           {full, prog_full, prog_empty, empty, overflow, underflow}, exp_flags);
      end
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if ({empty, sb.size() == 0} !== 2'b11) begin
      errors++; $display("FAIL b2b_end: got e=%b left=%0d expected e=1 left=0", empty, sb.size());
    end
  endtask

  function automatic logic flags_ok();
    return {full, prog_full, prog_empty, empty, overflow, underflow} === exp_flags;
  endfunction
`endif

  initial begin
    test_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`else
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
`endif
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised single-clock FIFO with programmable full/empty thresholds, occupancy count and overflow/underflow error flags. It is the general-purpose buffer between producer and consumer blocks in the same clock domain, replacing fixed-threshold FIFOs. A build-time macro selects standard (registered read) or first-word-fall-through output behaviour.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- PROG_FULL_THRESH, DEPTH-4, prog_full asserts when count ≥ this value (1..DEPTH-1)
- PROG_EMPTY_THRESH, 2, prog_empty asserts when count ≤ this value (0..DEPTH-2, < PROG_FULL_THRESH)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- din  in  WIDTH  write data
- rd_en  in  1  read request / consume strobe
- dout  out  WIDTH  read data
- valid  out  1  dout holds read data (see Operation)
- full  out  1  count == DEPTH
- empty  out  1  no readable word
- prog_full  out  1  count ≥ PROG_FULL_THRESH
- prog_empty  out  1  count ≤ PROG_EMPTY_THRESH
- data_count  out  $clog2(DEPTH)+1  words stored, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Write accepted iff wr_en && (!full || read accepted same cycle); rejected write → overflow=1 next cycle, storage unchanged.
- Read accepted iff rd_en && !empty; rejected read → underflow=1 next cycle; outputs otherwise unchanged.
- Empty + simultaneous rd_en/wr_en: write accepted, read rejected (underflow pulses).
- Full + simultaneous rd_en/wr_en: both accepted, count stays DEPTH, full stays 1.
- Write/read pointers $clog2(DEPTH) bits, wrap DEPTH-1 → 0 naturally; count tracked separately (+1 write, −1 read, unchanged both/neither).
- All flags and data_count are registered, derived from next-count so they are consistent with data_count every cycle.
- No state machine beyond FWFT output stage (Configuration).
- Reset (async, any time, including mid-burst): pointers/count 0, dout 0, valid 0, empty 1, full 0, prog_full 0, prog_empty 1, overflow 0, underflow 0. RAM contents not cleared.

## Timing
- Standard mode: accepted read at edge N → dout updated and valid=1 after edge N for one cycle; valid=0 otherwise, dout holds last value.
- Standard mode: write at edge N → empty=0, data_count=1 after edge N; readable next cycle.
- Flags update at the same edge as the causing access (no extra lag).
- overflow/underflow: high exactly one cycle after the offending edge.
- Back-to-back reads/writes every cycle sustained; throughput 1 word/cycle.

## Configuration
- Macro FIFO_FWFT_EN.
- Undefined: standard mode as above; valid is a one-cycle read-data strobe.
- Defined: first-word-fall-through. Output register prefetches head word; valid = !empty; dout shows head word while valid; rd_en acknowledges it and the next word (if any) appears after the same edge. Write into empty FIFO at edge N → valid=1/empty=0 after edge N+1. data_count includes the word in the output register; full/prog flags based on that total. Reset clears output stage (valid 0, dout 0).

## Structure
- Package fifo_pkg: ADDR_W/CNT_W derivation helper (clog2-based), parameter legality checks as constants.
- Sub-module sdp_ram (simple dual-port, one write port, one registered read port, WIDTH×DEPTH) instantiated once; control, count and flags in top.

## Test plan
- WIDTH=32, DEPTH=16, thresholds 12/2. After reset: empty=1, prog_empty=1, data_count=0, valid=0, dout=0.
- Write 16 random words, no reads → data_count 1..16; prog_empty clears at 3, prog_full sets at 12, full at 16; 17th write → overflow one-cycle pulse, count stays 16.
- Read 16 words → data identical and in order; prog_full clears at 11, prog_empty sets at 2, empty at 0; 17th read → underflow pulse, dout unchanged.
- Full FIFO, rd_en+wr_en together for 8 cycles → full stays 1, count 16, data order preserved across pointer wrap.
- Empty FIFO, rd_en+wr_en same cycle → underflow=1, count=1, word readable afterwards.
- Assert rst mid-burst at count=9 → all outputs return to reset values immediately (async); FIFO_FWFT_EN build: first write → valid after 2 edges, dout = written word without rd_en.
